// File: rtl/ser_pkg.sv
// Shared types and sizing helpers for the word serializer and its future deserializer peer.
package ser_pkg;

    localparam int unsigned DEFAULT_WIDTH = 12;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-counter width able to hold WIDTH-1; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/ser_bit_cnt.sv
// Bit-position counter for serial word framing; flags the last bit (WIDTH-1) and saturates there.
module ser_bit_cnt
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                          t_clk,
    input  logic                          r,
    input  logic                          clear,
    input  logic                          enable,
    output logic [cnt_width(WIDTH)-1:0]   cnt,
    output logic                          last
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // Clear wins over enable; holding at last keeps the count from wrapping.
    always_ff @(posedge t_clk) begin
        if (r || clear) begin
            cnt <= '0;
        end else if (enable && !last) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial feeder, LSB first, with a word-start strobe on bit 0.
// Define SER_BACK2BACK_EN to allow a new word to follow the last bit with no idle cycle.
module word_serializer
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_start,
    output logic             ser_valid,
    output logic             busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t             state;
    state_t             state_d;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shreg_d;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic               load;
    logic               cnt_clear;
    logic               cnt_en;
    logic               ready_d;

    assign load = in_valid && in_ready;

    ser_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .t_clk  (t_clk),
        .r      (r),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .cnt    (cnt),
        .last   (last)
    );

    // Next-state, shift-register and counter control.
    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        ready_d   = 1'b0;

        case (state)
            IDLE: begin
                if (load) begin
                    state_d   = SHIFT;
                    shreg_d   = in_data;
                    cnt_clear = 1'b1;
                end
            end
            SHIFT: begin
                shreg_d = shreg >> 1;
                cnt_en  = 1'b1;
                if (last) begin
                    cnt_clear = 1'b1;
`ifdef SER_BACK2BACK_EN
                    if (load) begin
                        shreg_d = in_data;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
        endcase

        ready_d = (state_d == IDLE);
`ifdef SER_BACK2BACK_EN
        // The cycle after this edge carries the last bit, so a follow-on word may be taken then.
        if (state == SHIFT && cnt == CNT_W'(WIDTH - 2)) begin
            ready_d = 1'b1;
        end
`endif
    end

    // State register with registered outputs derived from the next state.
    always_ff @(posedge t_clk) begin
        if (r) begin
            state     <= IDLE;
            shreg     <= '0;
            in_ready  <= 1'b1;
            ser_bit   <= 1'b0;
            ser_start <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            shreg     <= shreg_d;
            in_ready  <= ready_d;
            ser_bit   <= (state_d == SHIFT) && shreg_d[0];
            ser_start <= load;
            ser_valid <= (state_d == SHIFT);
            busy      <= (state_d == SHIFT);
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: vector table plus hand-written multi-cycle sequences.
module tb_word_serializer;

    localparam int unsigned W = 12;
`ifdef SER_BACK2BACK_EN
    localparam logic B2B = 1'b1;
`else
    localparam logic B2B = 1'b0;
`endif

    logic          t_clk = 1'b0;
    logic          r;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          ser_bit;
    logic          ser_start;
    logic          ser_valid;
    logic          busy;

    always #5 t_clk = ~t_clk;

    word_serializer #(
        .WIDTH (W)
    ) dut (
        .t_clk     (t_clk),
        .r         (r),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_bit   (ser_bit),
        .ser_start (ser_start),
        .ser_valid (ser_valid),
        .busy      (busy)
    );

    // Inputs applied before an edge; expected outputs observed after it.
    typedef struct {
        logic          r;
        logic          v;
        logic [W-1:0]  d;
        logic          rdy;
        logic          val;
        logic          st;
        logic          b;
        logic          bsy;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic r_i, input logic v_i, input logic [W-1:0] d_i,
                                input logic rdy_i, input logic val_i, input logic st_i,
                                input logic b_i, input logic bsy_i);
        vec_t e;
        e.r   = r_i;
        e.v   = v_i;
        e.d   = d_i;
        e.rdy = rdy_i;
        e.val = val_i;
        e.st  = st_i;
        e.b   = b_i;
        e.bsy = bsy_i;
        tbl.push_back(e);
    endfunction

    function automatic void add_idle(input logic r_i, input logic v_i, input logic [W-1:0] d_i);
        add(r_i, v_i, d_i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Whole word from an idle start: bit i appears after the i-th edge past the handshake.
    function automatic void add_word(input logic [W-1:0] d_i);
        for (int i = 0; i < int'(W); i++) begin
            add(1'b0, (i == 0), (i == 0) ? d_i : '0,
                (i == int'(W) - 1) ? B2B : 1'b0, 1'b1, (i == 0), d_i[i], 1'b1);
        end
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    logic [26:1]  cv, cs, cb, ev, es, eb;
    logic [W-1:0] word;
    int           acc;
    int           n;
    int           s2;

    initial begin
        r        = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset for two edges, then idle.
        repeat (2) add_idle(1'b1, 1'b0, '0);
        repeat (5) add_idle(1'b0, 1'b0, '0);
        // Request coincident with reset is dropped.
        add_idle(1'b1, 1'b1, 12'hFFF);
        add_idle(1'b0, 1'b0, '0);
        // Single word.
        add_word(12'h0A5);
        add_idle(1'b0, 1'b0, '0);
        // Reset while the fifth bit of 12'hFFF is on the line.
        for (int i = 0; i < 5; i++) begin
            add(1'b0, (i == 0), 12'hFFF, 1'b0, 1'b1, (i == 0), 1'b1, 1'b1);
        end
        add_idle(1'b1, 1'b0, '0);
        add_word(12'h003);
        add_idle(1'b0, 1'b0, '0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge t_clk);
            r        = tbl[i].r;
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            @(posedge t_clk);
            #1;
            chk("in_ready",  i, 32'(in_ready),  32'(tbl[i].rdy));
            chk("ser_valid", i, 32'(ser_valid), 32'(tbl[i].val));
            chk("ser_start", i, 32'(ser_start), 32'(tbl[i].st));
            chk("ser_bit",   i, 32'(ser_bit),   32'(tbl[i].b));
            chk("busy",      i, 32'(busy),      32'(tbl[i].bsy));
        end

        // Held request: 12'hFFF then 12'h001 presented continuously.
        s2  = B2B ? 13 : 14;
        acc = 0;
        for (int c = 1; c <= 26; c++) begin
            ev[c] = (c <= 12) || (c >= s2 && c < s2 + 12);
            es[c] = (c == 1) || (c == s2);
            eb[c] = (c <= 12) || (c == s2);
        end
        for (int c = 1; c <= 26; c++) begin
            @(negedge t_clk);
            in_valid = (acc < 2);
            in_data  = (acc == 0) ? 12'hFFF : 12'h001;
            if (in_valid && in_ready) acc++;
            @(posedge t_clk);
            #1;
            cv[c] = ser_valid;
            cs[c] = ser_start;
            cb[c] = ser_bit;
        end
        chk("held_valid", 0, 32'(cv), 32'(ev));
        chk("held_start", 0, 32'(cs), 32'(es));
        chk("held_bits",  0, 32'(cb), 32'(eb));
        chk("held_accepts", 0, 32'(acc), 32'd2);

        // in_data changes one cycle after the handshake; the word in flight must not.
        @(negedge t_clk);
        in_valid = 1'b1;
        in_data  = 12'h800;
        word     = '0;
        n        = 0;
        for (int c = 0; c < 13; c++) begin
            @(posedge t_clk);
            #1;
            if (ser_valid && n < int'(W)) begin
                word[n] = ser_bit;
                n++;
            end
            @(negedge t_clk);
            in_valid = 1'b0;
            in_data  = 12'hFFF;
        end
        chk("hold_word",  0, 32'(word), 32'h800);
        chk("hold_count", 0, 32'(n), 32'd12);
        chk("hold_idle",  0, 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
